// File: rtl/bit_serializer_pkg.sv
// Shared types and widths for the bit_serializer parallel-to-serial front end.
package bit_serializer_pkg;

    localparam int GAP_CNT_W  = 4;
    localparam int WORD_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } ser_state_t;

endpackage

// File: rtl/bit_serializer_shreg.sv
// WIDTH-bit load/shift register; the outgoing bit is read straight off the end flop.
module bit_serializer_shreg #(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    output logic             bit_out
);
    import bit_serializer_pkg::*;

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    // Zeros shift in behind the word, so the output reads 0 once the word has left.
    always_comb begin
        shreg_d = shreg_q;
        if (load) begin
            shreg_d = load_data;
        end else if (shift) begin
            shreg_d = (LSB_FIRST != 0) ? (shreg_q >> 1) : (shreg_q << 1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign bit_out = (LSB_FIRST != 0) ? shreg_q[0] : shreg_q[WIDTH-1];

endmodule

// File: rtl/bit_serializer.sv
// Serializes WIDTH-bit words accepted over valid/ready into a framed one-bit stream.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 0,
    parameter int GAP       = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_first,
    output logic             sout_last,
    output logic             busy,
    output logic [15:0]      word_cnt
);
    import bit_serializer_pkg::*;

    localparam int BIT_CNT_W = $clog2(WIDTH);

    ser_state_t             state_q, state_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [GAP_CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [WORD_CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic                   sout_valid_q, sout_valid_d;
    logic                   sout_first_q, sout_first_d;
    logic                   sout_last_q, sout_last_d;
    logic                   busy_q, busy_d;
    logic                   rdy_en_q;
    logic                   last_bit;
    logic                   accept;
    logic                   load;
    logic                   shift;

    assign last_bit = (state_q == SHIFT) && (bit_cnt_q == BIT_CNT_W'(WIDTH - 1));

    // rdy_en_q holds ready low for the first cycle after reset release.
    assign in_ready = rst && rdy_en_q &&
                      ((state_q == IDLE) || ((GAP == 0) && last_bit));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        word_cnt_d = word_cnt_q;
        load       = 1'b0;
        shift      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                    load      = 1'b1;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    word_cnt_d = word_cnt_q + 16'd1;
                    if (GAP == 0) begin
                        if (accept) begin
                            load      = 1'b1;
                            bit_cnt_d = '0;
                        end else begin
                            state_d = IDLE;
                            shift   = 1'b1;
                        end
                    end else begin
                        state_d   = bit_serializer_pkg::GAP;
                        gap_cnt_d = '0;
                        shift     = 1'b1;
                    end
                end else begin
                    shift     = 1'b1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            bit_serializer_pkg::GAP: begin
                if (gap_cnt_q == GAP_CNT_W'(GAP - 1)) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        sout_valid_d = (state_d == SHIFT);
        sout_first_d = load;
        sout_last_d  = (state_d == SHIFT) && (bit_cnt_d == BIT_CNT_W'(WIDTH - 1));
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            word_cnt_q   <= '0;
            sout_valid_q <= 1'b0;
            sout_first_q <= 1'b0;
            sout_last_q  <= 1'b0;
            busy_q       <= 1'b0;
            rdy_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            word_cnt_q   <= word_cnt_d;
            sout_valid_q <= sout_valid_d;
            sout_first_q <= sout_first_d;
            sout_last_q  <= sout_last_d;
            busy_q       <= busy_d;
            rdy_en_q     <= 1'b1;
        end
    end

    bit_serializer_shreg #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_shreg (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .shift     (shift),
        .load_data (in_data),
        .bit_out   (sout)
    );

    assign sout_valid = sout_valid_q;
    assign sout_first = sout_first_q;
    assign sout_last  = sout_last_q;
    assign busy       = busy_q;
    assign word_cnt   = word_cnt_q;

    // With WIDTH >= 2 a single bit can never open and close a word at once.
    a_first_not_last: assert property (@(posedge clk) disable iff (!rst)
                                       !(sout_first_q && sout_last_q));

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: three configurations checked every cycle against a word-timeline model.
module tb_bit_serializer;

    localparam int W = 8;
    localparam int N = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_data    [N];
    logic         in_valid   [N];
    logic         in_ready   [N];
    logic         sout       [N];
    logic         sout_valid [N];
    logic         sout_first [N];
    logic         sout_last  [N];
    logic         busy       [N];
    logic [15:0]  word_cnt   [N];
    logic         dout0;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    always #5 clk = ~clk;

    // Instance 0: MSB first, no gap. Instance 1: LSB first. Instance 2: MSB first, GAP=3.
    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_dut
            bit_serializer #(
                .WIDTH     (W),
                .LSB_FIRST ((g == 1) ? 1 : 0),
                .GAP       ((g == 2) ? 3 : 0)
            ) u_dut (
                .clk        (clk),
                .rst        (rst),
                .in_data    (in_data[g]),
                .in_valid   (in_valid[g]),
                .in_ready   (in_ready[g]),
                .sout       (sout[g]),
                .sout_valid (sout_valid[g]),
                .sout_first (sout_first[g]),
                .sout_last  (sout_last[g]),
                .busy       (busy[g]),
                .word_cnt   (word_cnt[g])
            );
        end
    endgenerate

    // Downstream register stage fed by instance 0's serial output.
    always @(posedge clk) dout0 <= sout[0];

    function automatic int gap_of(input int i);
        return (i == 2) ? 3 : 0;
    endfunction

    function automatic int lsb_of(input int i);
        return (i == 1) ? 1 : 0;
    endfunction

    // Reference model: m_pos is the cycle count since accept; bits occupy 0..W-1, gap W..W+GAP-1.
    bit           m_busy [N];
    bit           m_en   [N];
    logic [W-1:0] m_word [N];
    int           m_pos  [N];
    logic [15:0]  m_cnt  [N];
    logic         m_prev_sout0 = 1'b0;
    int           preload_req  = 0;
    int           preload_seen = 0;
    bit           acc_m;

    function automatic logic exp_ready(input int i);
        return rst && m_en[i] && (!m_busy[i] || ((gap_of(i) == 0) && (m_pos[i] == W - 1)));
    endfunction

    function automatic logic exp_sout(input int i);
        if (!(m_busy[i] && (m_pos[i] < W))) return 1'b0;
        return (lsb_of(i) != 0) ? m_word[i][m_pos[i]] : m_word[i][W - 1 - m_pos[i]];
    endfunction

    function automatic logic [31:0] exp_vec(input int i);
        logic v, f, l;
        v = m_busy[i] && (m_pos[i] < W);
        f = v && (m_pos[i] == 0);
        l = v && (m_pos[i] == W - 1);
        return {10'd0, exp_ready(i), exp_sout(i), v, f, l, m_busy[i], m_cnt[i]};
    endfunction

    function automatic logic [31:0] obs_vec(input int i);
        return {10'd0, in_ready[i], sout[i], sout_valid[i], sout_first[i], sout_last[i],
                busy[i], word_cnt[i]};
    endfunction

    always @(posedge clk) begin
        if (preload_seen != preload_req) begin
            m_cnt[0]     = 16'hFFFF;
            preload_seen = preload_req;
        end
        m_prev_sout0 = exp_sout(0);
        for (int i = 0; i < N; i++) begin
            acc_m = in_valid[i] && exp_ready(i);
            if (!rst) begin
                m_busy[i] = 1'b0;
                m_en[i]   = 1'b0;
                m_pos[i]  = 0;
                m_cnt[i]  = 16'd0;
            end else begin
                if (m_busy[i] && (m_pos[i] == W - 1)) m_cnt[i] = m_cnt[i] + 16'd1;
                if (m_busy[i]) begin
                    m_pos[i] = m_pos[i] + 1;
                    if (m_pos[i] == W + gap_of(i)) m_busy[i] = 1'b0;
                end
                if (acc_m) begin
                    m_busy[i] = 1'b1;
                    m_word[i] = in_data[i];
                    m_pos[i]  = 0;
                end
                m_en[i] = 1'b1;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s got=0x%08h expected=0x%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Stream trackers used by the directed scenarios.
    logic [7:0] cap0 = 8'd0;
    logic [7:0] cap1 = 8'd0;
    int run0 = 0, last_run0 = 0;
    int idle2 = 0, gap2 = 0;

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < N; i++) checkOutput($sformatf("outs%0d", i), obs_vec(i), exp_vec(i));
            checkOutput("dout0", 32'(dout0), 32'(m_prev_sout0));
        end
        if (sout_valid[0]) begin
            cap0 = {cap0[6:0], sout[0]};
            run0++;
        end else begin
            if (run0 > 0) last_run0 = run0;
            run0 = 0;
        end
        if (sout_valid[1]) cap1 = {sout[1], cap1[7:1]};
        if (sout_first[2]) begin
            gap2  = idle2;
            idle2 = 0;
        end else if (!sout_valid[2]) begin
            idle2++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input int i, input logic [W-1:0] d);
        in_valid[i] = 1'b1;
        in_data[i]  = d;
        tick(1);
        in_valid[i] = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            in_valid[i] = 1'b0;
            in_data[i]  = '0;
        end
        tick(3);
        chk_on = 1'b1;
        checkOutput("rst_ready", 32'(in_ready[0]), 32'h0);
        checkOutput("rst_cnt", 32'(word_cnt[2]), 32'h0);
        rst = 1'b1;
        tick(1);

        // Single words on all three instances.
        in_data[0] = 8'hA5;
        in_data[1] = 8'h01;
        in_data[2] = 8'h3C;
        for (int i = 0; i < N; i++) in_valid[i] = 1'b1;
        tick(1);
        for (int i = 0; i < N; i++) in_valid[i] = 1'b0;
        tick(12);
        checkOutput("seq_a5", 32'(cap0), 32'hA5);
        checkOutput("seq_01_lsb", 32'(cap1), 32'h01);
        checkOutput("cnt_single0", 32'(word_cnt[0]), 32'h1);
        checkOutput("cnt_single2", 32'(word_cnt[2]), 32'h1);

        // Back-to-back FF then 00 with valid held.
        in_valid[0] = 1'b1;
        in_data[0]  = 8'hFF;
        tick(1);
        in_data[0]  = 8'h00;
        tick(8);
        in_valid[0] = 1'b0;
        tick(10);
        checkOutput("b2b_run", 32'(last_run0), 32'd16);
        checkOutput("b2b_cnt", 32'(word_cnt[0]), 32'h3);

        // Two words through the GAP=3 instance.
        in_valid[2] = 1'b1;
        in_data[2]  = 8'h81;
        tick(1);
        in_data[2]  = 8'h7E;
        tick(12);
        in_valid[2] = 1'b0;
        tick(12);
        checkOutput("gap_idle", 32'(gap2), 32'd4);
        checkOutput("gap_cnt", 32'(word_cnt[2]), 32'h3);

        // Reset during bit 4 of 0xC3.
        applyStimulus(0, 8'hC3);
        tick(3);
        rst = 1'b0;
        tick(1);
        checkOutput("rstmid_cnt", 32'(word_cnt[0]), 32'h0);
        checkOutput("rstmid_valid", 32'(sout_valid[0]), 32'h0);
        checkOutput("rstmid_busy", 32'(busy[0]), 32'h0);
        rst = 1'b1;
        tick(1);
        applyStimulus(0, 8'h5A);
        tick(12);
        checkOutput("post_rst_seq", 32'(cap0), 32'h5A);
        checkOutput("post_rst_cnt", 32'(word_cnt[0]), 32'h1);

        // Counter wrap from a preloaded 0xFFFF.
        @(negedge clk);
        #1;
        force g_dut[0].u_dut.word_cnt_q = 16'hFFFF;
        preload_req = preload_req + 1;
        #1;
        release g_dut[0].u_dut.word_cnt_q;
        tick(1);
        applyStimulus(0, 8'h3C);
        tick(12);
        checkOutput("wrap_cnt", 32'(word_cnt[0]), 32'h0);

        // Random traffic with occasional resets.
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(63) != 0);
            for (int i = 0; i < N; i++) begin
                in_valid[i] = ($urandom_range(2) == 0);
                in_data[i]  = W'($urandom);
            end
            tick(1);
        end
        rst = 1'b1;
        for (int i = 0; i < N; i++) in_valid[i] = 1'b0;
        tick(20);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end for the single-bit register path: it accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on `sout`. `sout` drives the `din` input of the downstream D flip-flop stage, so that stage sees one framed bit stream. Framing strobes (`sout_valid`, `sout_first`, `sout_last`) and a completed-word counter let the s2cif-driven bench check the stream bit-exactly.

## Interface
- `WIDTH`, default 8: word width; legal range 2..32.
- `LSB_FIRST`, default 0: 0 shifts MSB first; 1 shifts LSB first.
- `GAP`, default 0: idle cycles inserted after each word; legal range 0..15.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `in_data`  in  WIDTH  word to serialize; sampled only on accept.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block can accept a word this cycle.
- `sout`  out  1  serial bit; feeds the downstream DFF `din`.
- `sout_valid`  out  1  `sout` carries a data bit.
- `sout_first`  out  1  first bit of a word.
- `sout_last`  out  1  last bit of a word.
- `busy`  out  1  state is not IDLE.
- `word_cnt`  out  16  count of completed words; wraps at 0xFFFF.

## Operation
- Accept happens when `in_valid && in_ready` at a rising edge. `in_data` is latched into the shift register at that edge, and later changes to `in_data` have no effect.
- States:
  - IDLE: `in_ready`=1 and `sout_valid`=0.
  - SHIFT: one bit per cycle, bit index 0..WIDTH-1.
  - GAP: `sout_valid`=0, counts GAP cycles.
- Transitions:
  - IDLE to SHIFT on accept.
  - SHIFT, last bit, GAP=0: go to SHIFT if `in_valid`, otherwise IDLE.
  - SHIFT, last bit, GAP>0: go to GAP.
  - GAP to IDLE after GAP cycles.
- `in_ready` is 1 in IDLE. It is also 1 during the last-bit SHIFT cycle when GAP=0, which gives back-to-back words. It is 0 in every other case.
- Bit order: LSB_FIRST=0 emits `in_data[WIDTH-1]` down to `in_data[0]`. LSB_FIRST=1 emits `in_data[0]` up to `in_data[WIDTH-1]`.
- `sout` is 0 whenever `sout_valid` is 0.
- `word_cnt` increments by 1 at the edge that ends each last-bit cycle, using modulo-2^16 arithmetic.
- Reset (rst=0 at an edge):
  - State goes to IDLE.
  - `sout`, `sout_valid`, `sout_first`, `sout_last`, `busy` and `word_cnt` all go to 0.
  - `in_ready` is 0 while rst=0.
  - Reset mid-word aborts the word. The partial word is dropped and is not counted.

## Timing
- All data and strobe outputs are registered. `in_ready` is decoded from registered state gated by `rst`.
- Accept at edge E0 gives `sout` = bit 0 of the word in the cycle after E0, with `sout_first`=1.
- Bit k is valid in the cycle after edge E0+k.
- `sout_last`=1 in the cycle after edge E0+WIDTH-1.
- The downstream DFF presents each bit one cycle later again.
- Throughput:
  - GAP=0 with continuous `in_valid`: 1 word per WIDTH cycles, with no bubble.
  - GAP>0: 1 word per WIDTH+GAP+1 cycles, because an IDLE cycle sits between the gap and the next accept.
- If `sout_first` and `sout_last` would both be set (WIDTH≥2), that is an error. An assertion checks that they are never both 1.
- First accept after reset release: rst=1 sampled at edge R sets `in_ready`=1 in the cycle after R, so the earliest accept is at edge R+1.

## Structure
- The package `bit_serializer_pkg` holds:
  - the state enum typedef `ser_state_t` (IDLE, SHIFT, GAP);
  - `GAP_CNT_W` = 4;
  - `WORD_CNT_W` = 16.
- Sub-module `bit_serializer_shreg` is the WIDTH-bit load/shift register. Its inputs are load, shift and the LSB_FIRST parameter, and its output is the current bit.
- The FSM, bit counter, gap counter and word counter stay in the top module.

## Test plan
- Reset then single word: WIDTH=8, LSB_FIRST=0, send 0xA5. The required `sout` sequence is 1,0,1,0,0,1,0,1 with `sout_first` on the first bit and `sout_last` on the eighth. `word_cnt` must read 1, and downstream `dout` must show the same sequence one cycle later.
- LSB_FIRST=1, send 0x01. Required `sout` is 1,0,0,0,0,0,0,0.
- Back-to-back with GAP=0: send 0xFF then 0x00 with `in_valid` held high. Required result is 16 contiguous `sout_valid` cycles with no bubble, `in_ready` high on the 8th bit, and `word_cnt`=2.
- GAP=3: send two words. Required result is exactly 3 `sout_valid`=0 cycles plus 1 IDLE cycle between the words.
- Reset mid-operation: assert rst=0 during bit 4 of 0xC3. All outputs must be 0 at the next edge, `word_cnt`=0, and the next word must serialize cleanly.
- Counter wrap: preload the count to 0xFFFF via a bench backdoor or 65535 words, then complete one word. `word_cnt` must read 0x0000.
